traffic_phase_controller: RTL

//  Main/side intersection sequencer; initiator for Timer's start_timer/input_value/expired interface.

---
 rtl/traffic_phase_controller_if.sv | 20 ++
 rtl/traffic_phase_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller_if.sv
// Timer handshake between the phase controller (master) and the countdown Timer (slave).
// The master loads a duration with a one-clock start pulse; the Timer reports completion
// with a level that is high while its count is zero.
interface traffic_phase_controller_if;
    logic       start_timer;
    logic [3:0] input_value;
    logic       expired;

    modport master (
        output start_timer,
        output input_value,
        input  expired
    );

    modport slave (
        input  start_timer,
        input  input_value,
        output expired
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Main/side intersection sequencer. Walks the six-phase cycle
// MAIN_G -> MAIN_Y -> RED1 -> SIDE_G -> SIDE_Y -> RED2, loading the external Timer
// once per phase entry (or per main-green extension) and advancing when it expires.
// Main green is extended while the side road is empty and no walk is pending; a latched
// walk request turns the next all-red phase into a longer walk phase.
module traffic_phase_controller #(
    parameter logic [3:0] T_GREEN_MAIN = 4'd8,
    parameter logic [3:0] T_GREEN_SIDE = 4'd5,
    parameter logic [3:0] T_YELLOW     = 4'd2,
    parameter logic [3:0] T_ALLRED     = 4'd1,
    parameter logic [3:0] T_WALK       = 4'd6
) (
    input  logic                              clk,
    input  logic                              sys_reset,
    traffic_phase_controller_if.master        tmr,
    input  logic                              side_sensor_i,
    input  logic                              walk_req_i,
    output logic [2:0]                        main_light_o,
    output logic [2:0]                        side_light_o,
    output logic                              walk_o
);

    // Plain 3-bit encoding so that the unused codes remain reachable for recovery.
    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] RED1   = 3'd2;
    localparam logic [2:0] SIDE_G = 3'd3;
    localparam logic [2:0] SIDE_Y = 3'd4;
    localparam logic [2:0] RED2   = 3'd5;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [2:0] state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] ival_q,  ival_d;
    logic [2:0] main_q,  main_d;
    logic [2:0] side_q,  side_d;
    logic       walk_q,  walk_d;
    logic       pend_q,  pend_d;
    logic       blank_q, blank_d;

    logic       phase_end;
    logic       load;
    logic       illegal;
    logic       walk_entry;

    // Duration loaded into the Timer when entering state s.
    function automatic logic [3:0] phase_duration(input logic [2:0] s, input logic walk_sel);
        logic [3:0] d;
        case (s)
            MAIN_G:         d = T_GREEN_MAIN;
            MAIN_Y, SIDE_Y: d = T_YELLOW;
            SIDE_G:         d = T_GREEN_SIDE;
            RED1, RED2:     d = walk_sel ? T_WALK : T_ALLRED;
            default:        d = T_ALLRED;
        endcase
        return d;
    endfunction

    // Main-road head for state s; anything unknown shows red.
    function automatic logic [2:0] main_lamp(input logic [2:0] s);
        logic [2:0] l;
        case (s)
            MAIN_G:  l = LAMP_GREEN;
            MAIN_Y:  l = LAMP_YELLOW;
            default: l = LAMP_RED;
        endcase
        return l;
    endfunction

    // Side-road head for state s; anything unknown shows red.
    function automatic logic [2:0] side_lamp(input logic [2:0] s);
        logic [2:0] l;
        case (s)
            SIDE_G:  l = LAMP_GREEN;
            SIDE_Y:  l = LAMP_YELLOW;
            default: l = LAMP_RED;
        endcase
        return l;
    endfunction

    // State and registered outputs; reset re-arms the Timer with a main-green load.
    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            state_q <= MAIN_G;
            start_q <= 1'b1;
            ival_q  <= T_GREEN_MAIN;
            main_q  <= LAMP_GREEN;
            side_q  <= LAMP_RED;
            walk_q  <= 1'b0;
            pend_q  <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            ival_q  <= ival_d;
            main_q  <= main_d;
            side_q  <= side_d;
            walk_q  <= walk_d;
            pend_q  <= pend_d;
            blank_q <= blank_d;
        end
    end

    // Next state: advance on a non-blanked expiry, recover from unknown codes via RED1.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        illegal = 1'b0;
        // A stale expired from the previous phase is masked in the pulse cycle and the one after.
        phase_end = tmr.expired & ~start_q & ~blank_q;
        case (state_q)
            MAIN_G: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = (side_sensor_i || pend_q) ? MAIN_Y : MAIN_G;
                end
            end
            MAIN_Y: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = RED1;
                end
            end
            RED1: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = SIDE_G;
                end
            end
            SIDE_G: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = SIDE_Y;
                end
            end
            SIDE_Y: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = RED2;
                end
            end
            RED2: begin
                if (phase_end) begin
                    load    = 1'b1;
                    state_d = MAIN_G;
                end
            end
            default: begin
                illegal = 1'b1;
                load    = 1'b1;
                state_d = RED1;
            end
        endcase
    end

    // Output next values: timer load, lamps for the upcoming state, walk latch bookkeeping.
    always_comb begin
        walk_entry = load & ~illegal & pend_q & ((state_d == RED1) || (state_d == RED2));
        start_d    = load;
        ival_d     = load ? phase_duration(state_d, walk_entry) : ival_q;
        main_d     = main_lamp(state_d);
        side_d     = side_lamp(state_d);
        walk_d     = load ? walk_entry : walk_q;
        // A press in the consuming cycle survives for the following all-red.
        pend_d     = walk_req_i | (pend_q & ~walk_entry);
        blank_d    = start_q;
    end

    assign tmr.start_timer = start_q;
    assign tmr.input_value = ival_q;
    assign main_light_o    = main_q;
    assign side_light_o    = side_q;
    assign walk_o          = walk_q;

endmodule
